// File: rtl/led_7seg_scan_if.sv
// Display-side bundle for led_7seg_scan: scan control and data in,
// active-low digit/segment drive and the frame snapshot strobe out.
interface led_7seg_scan_if;
    logic        enable;
    logic [31:0] data_in;
    logic [3:0]  dig_n;
    logic [7:0]  seg_n;
    logic        frame_tick;

    // Producer of the display word (PIO side / testbench)
    modport master (
        output enable,
        output data_in,
        input  dig_n,
        input  seg_n,
        input  frame_tick
    );

    // The scanner itself
    modport slave (
        input  enable,
        input  data_in,
        output dig_n,
        output seg_n,
        output frame_tick
    );
endinterface

// File: rtl/led_7seg_scan.sv
// led_7seg_scan: time-multiplexes four common-anode 7-segment digits.
// Each digit slot lasts SCAN_DIV cycles; the first BLANK_CYCLES of a slot
// keep every digit dark so the previous digit's pattern cannot ghost.
// The display word is captured once per frame (digit 0, count 0), so a
// mid-frame software update never tears the visible frame.
// Optional build macro LED_7SEG_HEX_DECODE_EN: interpret the word as hex
// nibbles + decimal points + per-digit blank mask instead of raw segments.
module led_7seg_scan #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic          clk,
    input  logic          reset_n,
    led_7seg_scan_if.slave bus
);

    localparam logic [15:0] CNT_LAST  = 16'(SCAN_DIV - 1);
    localparam logic [15:0] BLANK_END = 16'(BLANK_CYCLES);

`ifdef LED_7SEG_HEX_DECODE_EN
    // Hex nibble to segments g..a (active high)
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            4'hF:    seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    // Active-high segment pattern (dp..a) for digit idx from the snapshot
    function automatic logic [7:0] pattern(input logic [31:0] word, input logic [1:0] idx);
        logic [3:0] nib;
        logic       dp;
        logic       mask;
        case (idx)
            2'd0:    begin nib = word[3:0];   dp = word[16]; mask = word[20]; end
            2'd1:    begin nib = word[7:4];   dp = word[17]; mask = word[21]; end
            2'd2:    begin nib = word[11:8];  dp = word[18]; mask = word[22]; end
            2'd3:    begin nib = word[15:12]; dp = word[19]; mask = word[23]; end
            default: begin nib = 4'h0;        dp = 1'b0;     mask = 1'b1;     end
        endcase
        return mask ? 8'h00 : {dp, hex_to_seg(nib)};
    endfunction
`else
    // Active-high segment pattern (dp..a) for digit idx: raw byte idx
    function automatic logic [7:0] pattern(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] seg;
        case (idx)
            2'd0:    seg = word[7:0];
            2'd1:    seg = word[15:8];
            2'd2:    seg = word[23:16];
            2'd3:    seg = word[31:24];
            default: seg = 8'h00;
        endcase
        return seg;
    endfunction
`endif

    logic [15:0] cnt_r;
    logic [1:0]  dig_r;
    logic [31:0] shot_r;
    logic [3:0]  dig_n_r;
    logic [7:0]  seg_n_r;
    logic        frame_tick_r;

    logic [15:0] cnt_nxt_s;
    logic [1:0]  dig_nxt_s;
    logic [31:0] shot_nxt_s;
    logic [3:0]  dig_n_nxt_s;
    logic [7:0]  seg_n_nxt_s;
    logic        frame_tick_nxt_s;
    logic        blank_s;
    logic        snap_s;

    assign blank_s = (cnt_r < BLANK_END);
    assign snap_s  = bus.enable && (dig_r == 2'd0) && (cnt_r == 16'd0);

    // Next scan position, snapshot and output drive for the current phase
    always_comb begin
        cnt_nxt_s        = 16'd0;
        dig_nxt_s        = 2'd0;
        shot_nxt_s       = shot_r;
        dig_n_nxt_s      = 4'hF;
        seg_n_nxt_s      = 8'hFF;
        frame_tick_nxt_s = 1'b0;
        if (!bus.enable) begin
            cnt_nxt_s        = 16'd0;
            dig_nxt_s        = 2'd0;
            dig_n_nxt_s      = 4'hF;
            seg_n_nxt_s      = 8'hFF;
            frame_tick_nxt_s = 1'b0;
        end else begin
            // Counter wrap and digit advance happen together
            if (cnt_r == CNT_LAST) begin
                cnt_nxt_s = 16'd0;
                dig_nxt_s = dig_r + 2'd1;
            end else begin
                cnt_nxt_s = cnt_r + 16'd1;
                dig_nxt_s = dig_r;
            end
            // Count 0 is always in the blank phase, so loading the snapshot
            // here never changes a lit pattern mid-slot
            if (snap_s) begin
                shot_nxt_s = bus.data_in;
            end else begin
                shot_nxt_s = shot_r;
            end
            frame_tick_nxt_s = snap_s;
            if (blank_s) begin
                dig_n_nxt_s = 4'hF;
                seg_n_nxt_s = 8'hFF;
            end else begin
                dig_n_nxt_s = ~(4'b0001 << dig_r);
                seg_n_nxt_s = ~pattern(shot_r, dig_r);
            end
        end
    end

    // Scan state, snapshot and registered pin drive; reset goes dark at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r        <= 16'd0;
            dig_r        <= 2'd0;
            shot_r       <= 32'd0;
            dig_n_r      <= 4'hF;
            seg_n_r      <= 8'hFF;
            frame_tick_r <= 1'b0;
        end else begin
            cnt_r        <= cnt_nxt_s;
            dig_r        <= dig_nxt_s;
            shot_r       <= shot_nxt_s;
            dig_n_r      <= dig_n_nxt_s;
            seg_n_r      <= seg_n_nxt_s;
            frame_tick_r <= frame_tick_nxt_s;
        end
    end

    assign bus.dig_n      = dig_n_r;
    assign bus.seg_n      = seg_n_r;
    assign bus.frame_tick = frame_tick_r;

endmodule

// File: tb/tb_led_7seg_scan.sv
// Testbench for led_7seg_scan (raw segment mode, SCAN_DIV=8, BLANK_CYCLES=2).
// Stimulus pushes the expected pin state for every clock edge into a queue;
// the monitor pops and compares after each edge.
module tb_led_7seg_scan;

    localparam int SD = 8;
    localparam int BC = 2;
    localparam int FRAME = 4 * SD;

    typedef struct packed {
        logic [3:0] d;
        logic [7:0] s;
        logic       t;
    } exp_t;

    logic clk;
    logic reset_n;
    led_7seg_scan_if bus();

    led_7seg_scan #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    exp_t        q[$];
    exp_t        mon_e;
    int          vectors;
    int          miscompares;
    int          pos;
    logic [31:0] snap;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // Monitor: compares the DUT pins with the queued expectation after each edge
    always @(posedge clk) begin
        #2;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            check("dig_n", {28'd0, bus.dig_n}, {28'd0, mon_e.d});
            check("seg_n", {24'd0, bus.seg_n}, {24'd0, mon_e.s});
            check("frame_tick", {31'd0, bus.frame_tick}, {31'd0, mon_e.t});
            check("one_digit_max", {31'd0, ($countones(~bus.dig_n) <= 1)}, 32'd1);
        end
    end

    // Advance n edges, queuing the expected pins for each from frame position
    task automatic step(input int n);
        int   slot;
        int   c;
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (bus.enable) begin
                if (pos == 0) snap = bus.data_in;
                slot = pos / SD;
                c    = pos % SD;
                if (c < BC) begin
                    e.d = 4'hF;
                    e.s = 8'hFF;
                end else begin
                    e.d = ~(4'b0001 << slot);
                    e.s = ~snap[8*slot +: 8];
                end
                e.t = (pos == 0);
                pos = (pos + 1) % FRAME;
            end else begin
                e.d = 4'hF;
                e.s = 8'hFF;
                e.t = 1'b0;
                pos = 0;
            end
            q.push_back(e);
            #3;
        end
    endtask

    task automatic check_pins(input string name, input logic [3:0] d, input logic [7:0] s);
        check({name, "_dig_n"}, {28'd0, bus.dig_n}, {28'd0, d});
        check({name, "_seg_n"}, {24'd0, bus.seg_n}, {24'd0, s});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        pos         = 0;
        snap        = 32'd0;
        reset_n     = 1'b1;
        bus.enable  = 1'b0;
        bus.data_in = 32'd0;
        #1 reset_n = 1'b0;
        #1;
        check_pins("reset", 4'hF, 8'hFF);
        check("reset_tick", {31'd0, bus.frame_tick}, 32'd0);
        repeat (2) @(posedge clk);
        #3;
        reset_n     = 1'b1;
        bus.enable  = 1'b1;
        bus.data_in = 32'h4F5B063F;

        // Two full frames of plain scanning
        step(2 * FRAME);
        step(3);
        check_pins("lit_d0", 4'hE, 8'hC0);
        step(8);
        check_pins("lit_d1", 4'hD, 8'hF9);
        step(8);
        check_pins("lit_d2", 4'hB, 8'hA4);

        // Tearing: new word mid digit 2 must not show until the next frame
        bus.data_in = 32'h0;
        step(8);
        check_pins("tear_d3", 4'h7, 8'hB0);
        step(5);
        step(3);
        check_pins("next_frame_d0", 4'hE, 8'hFF);

        // Mid-slot reset during digit 1
        bus.data_in = 32'h4F5B063F;
        step(29);
        step(FRAME + 8 + 3);
        reset_n = 1'b0;
        #1;
        check_pins("async_reset", 4'hF, 8'hFF);
        pos = 0;
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
        step(2);
        check_pins("post_reset_dark", 4'hF, 8'hFF);
        step(1);
        check_pins("post_reset_d0", 4'hE, 8'hC0);
        step(37);

        // Enable dropped for 5 cycles in the middle of digit 3
        step(20);
        bus.enable = 1'b0;
        step(5);
        check_pins("disabled", 4'hF, 8'hFF);
        bus.enable = 1'b1;
        step(1);
        check("reenable_tick", {31'd0, bus.frame_tick}, 32'd1);
        step(2);
        check_pins("reenable_d0", 4'hE, 8'hC0);
        step(29);

        // Random data and enable activity
        for (int i = 0; i < 1000; i++) begin
            bus.enable  = ($urandom_range(0, 7) != 0);
            bus.data_in = $urandom;
            step(1);
        end
        bus.enable = 1'b1;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
